// File: rtl/param_reload_counter.sv
// ---------------------------------------------------------------------------
// param_reload_counter
//
// A period generator and one-shot delay timer. It counts up (0..reload) or
// down (reload..0) and has a programmable reload/terminal register. In
// auto-reload mode it keeps running and gives a periodic terminal pulse. In
// one-shot mode it stops in DONE at the terminal value.
//
// States:
//   state | meaning
//   IDLE  | not counting, count holds, waiting for start_i
//   RUN   | counting on enabled cycles
//   DONE  | one-shot finished, count holds at the terminal value
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   en_i          count enable (effective only in RUN)
//   up_down       1 = up, 0 = down (live)
//   mode_i        0 = auto-reload, 1 = one-shot (latched on start)
//   start_i       start / restart
//   stop_i        abort to IDLE, count holds
//   load_i        load count with load_val_i
//   load_val_i    load value
//   reload_wr_i   write reload_val_i into the reload register
//   reload_val_i  new reload / terminal value
//   count         current count
//   tc_o          one-cycle terminal-count pulse
//   done_o        high while in DONE
//   busy_o        high while in RUN
//   wrap_cnt_o    saturating count of terminal events since start
// ---------------------------------------------------------------------------
module param_reload_counter #(
    parameter int              WIDTH        = 8,
    parameter int              CNT_W        = 8,
    parameter logic [WIDTH-1:0] RESET_RELOAD = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             up_down,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             reload_wr_i,
    input  logic [WIDTH-1:0] reload_val_i,
    output logic [WIDTH-1:0] count,
    output logic             tc_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] wrap_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WRAP_MX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_oneshot;
    logic             r_tc;
    logic [CNT_W-1:0] r_wrap;

    logic             w_stop;
    logic             w_terminal;
    logic [WIDTH-1:0] w_start_val;
    logic [WIDTH-1:0] w_reload_val;

    // stop_i has no effect in IDLE, so it cannot mask a start there.
    assign w_stop       = stop_i && (r_state != S_IDLE);

    // Up mode only terminates on an exact match; a count above the reload
    // value simply rolls over through 0 and keeps climbing.
    assign w_terminal   = up_down ? (r_count == r_reload) : (r_count == '0);
    assign w_start_val  = up_down ? '0 : r_reload;
    assign w_reload_val = up_down ? '0 : r_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= RESET_RELOAD;
            r_oneshot <= 1'b0;
            r_tc      <= 1'b0;
            r_wrap    <= '0;
        end else begin
            r_tc <= 1'b0;

            // The old r_reload is still visible to the terminal compare
            // below, so a write here only affects later cycles.
            if (reload_wr_i) begin
                r_reload <= reload_val_i;
            end

            if (w_stop) begin
                r_state <= S_IDLE;
            end else if (start_i) begin
                r_state   <= S_RUN;
                r_oneshot <= mode_i;
                r_wrap    <= '0;
            end

            if (load_i) begin
                r_count <= load_val_i;
            end else if (w_stop) begin
                r_count <= r_count;
            end else if (start_i) begin
                r_count <= w_start_val;
            end else if ((r_state == S_RUN) && en_i) begin
                if (w_terminal) begin
                    r_tc <= 1'b1;
                    if (r_wrap != WRAP_MX) begin
                        r_wrap <= r_wrap + ONE_C;
                    end
                    if (r_oneshot) begin
                        r_state <= S_DONE;
                    end else begin
                        r_count <= w_reload_val;
                    end
                end else if (up_down) begin
                    r_count <= r_count + ONE_W;
                end else begin
                    r_count <= r_count - ONE_W;
                end
            end
        end
    end

    assign count      = r_count;
    assign tc_o       = r_tc;
    assign done_o     = (r_state == S_DONE);
    assign busy_o     = (r_state == S_RUN);
    assign wrap_cnt_o = r_wrap;

endmodule

// File: tb/tb_param_reload_counter.sv
// ---------------------------------------------------------------------------
// tb_param_reload_counter
//
// Directed bench for param_reload_counter at WIDTH=4, CNT_W=2 (small enough
// to reach wrap-count saturation). It runs a behavioural timer model
// alongside the DUT and compares every output on every falling edge. It also
// has hand-computed literal checks at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_param_reload_counter;

    localparam int WIDTH    = 4;
    localparam int CNT_W    = 2;
    localparam int MOD      = 1 << WIDTH;
    localparam int WRAP_MAX = (1 << CNT_W) - 1;
    localparam int RST_REL  = MOD - 1;

    logic             clk;
    logic             reset;
    logic             en_i;
    logic             up_down;
    logic             mode_i;
    logic             start_i;
    logic             stop_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             reload_wr_i;
    logic [WIDTH-1:0] reload_val_i;
    logic [WIDTH-1:0] count;
    logic             tc_o;
    logic             done_o;
    logic             busy_o;
    logic [CNT_W-1:0] wrap_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    param_reload_counter #(
        .WIDTH        (WIDTH),
        .CNT_W        (CNT_W),
        .RESET_RELOAD ({WIDTH{1'b1}})
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en_i         (en_i),
        .up_down      (up_down),
        .mode_i       (mode_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .load_i       (load_i),
        .load_val_i   (load_val_i),
        .reload_wr_i  (reload_wr_i),
        .reload_val_i (reload_val_i),
        .count        (count),
        .tc_o         (tc_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .wrap_cnt_o   (wrap_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: phase is "idle", "running" or "finished".
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_FIN  = 2;

    int m_phase, m_count, m_reload, m_wraps;
    bit m_oneshot, m_tc;

    always @(posedge clk) begin
        int  was_phase, old_reload;
        bit  halt, go, hit;
        if (reset) begin
            m_phase = PH_IDLE; m_count = 0; m_reload = RST_REL;
            m_wraps = 0; m_oneshot = 0; m_tc = 0;
        end else begin
            was_phase  = m_phase;
            old_reload = m_reload;
            m_tc = 0;
            if (reload_wr_i) m_reload = int'(reload_val_i);
            halt = stop_i && (was_phase != PH_IDLE);
            go   = start_i && !halt;
            if (halt) m_phase = PH_IDLE;
            else if (go) begin
                m_phase = PH_RUN; m_oneshot = mode_i; m_wraps = 0;
            end
            if (load_i) m_count = int'(load_val_i);
            else if (go) m_count = up_down ? 0 : old_reload;
            else if (!halt && was_phase == PH_RUN && en_i) begin
                hit = up_down ? (m_count == old_reload) : (m_count == 0);
                if (hit) begin
                    m_tc = 1;
                    if (m_wraps < WRAP_MAX) m_wraps = m_wraps + 1;
                    if (m_oneshot) m_phase = PH_FIN;
                    else m_count = up_down ? 0 : old_reload;
                end else begin
                    m_count = up_down ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_count", int'(count), m_count);
        chk("model_tc",    int'(tc_o), int'(m_tc));
        chk("model_done",  int'(done_o), int'(m_phase == PH_FIN));
        chk("model_busy",  int'(busy_o), int'(m_phase == PH_RUN));
        chk("model_wrap",  int'(wrap_cnt_o), m_wraps);
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic lit(input string tag, input int c, input int t, input int d,
                       input int b, input int w);
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_tc"},    int'(tc_o), t);
        chk({tag, "_done"},  int'(done_o), d);
        chk({tag, "_busy"},  int'(busy_o), b);
        chk({tag, "_wrap"},  int'(wrap_cnt_o), w);
    endtask

    initial begin
        reset = 1; en_i = 0; up_down = 1; mode_i = 0; start_i = 0; stop_i = 0;
        load_i = 0; load_val_i = '0; reload_wr_i = 0; reload_val_i = '0;

        // 1: reset and default reload of 15
        cyc(3);
        lit("reset", 0, 0, 0, 0, 0);
        reset = 0; en_i = 1; up_down = 1; start_i = 1;
        cyc(1); start_i = 0;
        lit("t1_start", 0, 0, 0, 1, 0);
        cyc(15);
        lit("t1_top", 15, 0, 0, 1, 0);
        cyc(1);
        lit("t1_wrap", 0, 1, 0, 1, 1);

        // 2: auto up with reload 5, wrap count saturates at 3
        reload_wr_i = 1; reload_val_i = 4'd5;
        cyc(1); reload_wr_i = 0; start_i = 1;
        cyc(1); start_i = 0;
        lit("t2_start", 0, 0, 0, 1, 0);
        cyc(5);
        lit("t2_five", 5, 0, 0, 1, 0);
        cyc(1);
        lit("t2_wrap1", 0, 1, 0, 1, 1);
        cyc(6);
        lit("t2_wrap2", 0, 1, 0, 1, 2);
        cyc(12);
        lit("t2_sat", 0, 1, 0, 1, 3);

        // 3: load 3 and count down, then enable gap
        load_i = 1; load_val_i = 4'd3; up_down = 0;
        cyc(1); load_i = 0;
        lit("t3_load", 3, 0, 0, 1, 3);
        cyc(3);
        lit("t3_zero", 0, 0, 0, 1, 3);
        cyc(1);
        lit("t3_reload", 5, 1, 0, 1, 3);
        en_i = 0;
        cyc(2);
        lit("t3_hold", 5, 0, 0, 1, 3);
        en_i = 1;
        cyc(2);

        // 4: one-shot up
        up_down = 1; mode_i = 1; start_i = 1;
        cyc(1); start_i = 0; mode_i = 0;
        lit("t4_start", 0, 0, 0, 1, 0);
        cyc(5);
        lit("t4_five", 5, 0, 0, 1, 0);
        cyc(1);
        lit("t4_done", 5, 1, 1, 0, 1);
        cyc(3);
        lit("t4_hold", 5, 0, 1, 0, 1);
        start_i = 1;
        cyc(1); start_i = 0;
        lit("t4_restart", 0, 0, 0, 1, 0);

        // 5: out-of-range load, then load+stop
        load_i = 1; load_val_i = 4'd12;
        cyc(1); load_i = 0;
        cyc(4);
        lit("t5_roll", 0, 0, 0, 1, 0);
        cyc(6);
        lit("t5_tc", 0, 1, 0, 1, 1);
        cyc(2);
        load_i = 1; stop_i = 1; load_val_i = 4'd9;
        cyc(1); load_i = 0; stop_i = 0;
        lit("t5_ldstop", 9, 0, 0, 0, 1);
        cyc(2);
        lit("t5_idle", 9, 0, 0, 0, 1);

        // 6: reset beats reload write; live reload write below current count
        start_i = 1;
        cyc(1); start_i = 0;
        cyc(3);
        lit("t6_three", 3, 0, 0, 1, 0);
        reset = 1; reload_wr_i = 1; reload_val_i = 4'd7;
        cyc(1); reset = 0; reload_wr_i = 0;
        lit("t6_reset", 0, 0, 0, 0, 0);
        start_i = 1;
        cyc(1); start_i = 0;
        cyc(4);
        lit("t6_four", 4, 0, 0, 1, 0);
        reload_wr_i = 1; reload_val_i = 4'd2;
        cyc(1); reload_wr_i = 0;
        lit("t6_five", 5, 0, 0, 1, 0);
        cyc(10);
        lit("t6_top", 15, 0, 0, 1, 0);
        cyc(1);
        lit("t6_roll", 0, 0, 0, 1, 0);
        cyc(3);
        lit("t6_tc", 0, 1, 0, 1, 1);

        // stop mid-run holds count
        cyc(1);
        stop_i = 1;
        cyc(1); stop_i = 0;
        lit("stop", 1, 0, 0, 0, 1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/param_reload_counter.md
Name: param_reload_counter

Overview:
Parametrised successor to the team's 4-bit self-reloading up/down counter. It adds a programmable reload register, run control (IDLE/RUN/DONE), an auto-reload or one-shot mode, count enable, a terminal-count pulse and a saturating reload counter. It is used as a generic timer/period generator wherever a block needs a periodic tick or a one-shot delay.

Parameters:
WIDTH, 8, counter and reload value width in bits (>=2)
CNT_W, 8, width of the reload-event counter wrap_cnt_o
RESET_RELOAD, {WIDTH{1'b1}}, reset value of the internal reload register reload_q

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
en_i  input  1  count enable; counting happens only in RUN with en_i=1
up_down  input  1  1 = count up, 0 = count down; live, may change mid-run
mode_i  input  1  0 = auto-reload, 1 = one-shot; latched on start
start_i  input  1  start or restart counting
stop_i  input  1  abort to IDLE, count holds its value
load_i  input  1  load count with load_val_i this cycle
load_val_i  input  WIDTH  value for load_i
reload_wr_i  input  1  write reload_val_i into reload_q
reload_val_i  input  WIDTH  new reload/terminal value
count  output  WIDTH  current count (registered)
tc_o  output  1  one-cycle terminal-count pulse (registered)
done_o  output  1  high while in DONE (one-shot finished)
busy_o  output  1  high while in RUN
wrap_cnt_o  output  CNT_W  number of terminal events since start, saturating

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE, count=0, reload_q=RESET_RELOAD, mode_q=0, tc_o=0, done_o=0, busy_o=0, wrap_cnt_o=0. Reset mid-run aborts immediately at the next edge.
- Terminal value: up mode counts 0..reload_q; terminal when count==reload_q, next count=0. Down mode counts reload_q..0; terminal when count==0, next count=reload_q. Period is reload_q+1 enabled cycles.
- Terminal comparison and reload use the reload_q value held before the edge. A reload_wr_i in the same cycle takes effect from the next cycle.
- Up mode with count>reload_q: increments modulo 2^WIDTH (max -> 0) with no tc. Counting continues until count==reload_q. Down mode needs no special case.
- States:
  - IDLE: count holds. start_i -> RUN.
  - RUN: if en_i=1, count steps each cycle. If en_i=0, count holds and no tc is generated. At terminal: auto mode reloads and stays in RUN; one-shot mode goes to DONE and count holds at the terminal value (no reload).
  - DONE: count holds regardless of en_i. start_i -> RUN.
- start_i (from any state): mode_q<=mode_i, wrap_cnt_o<=0, state<=RUN. Count is set to the start value (0 if up_down=1, reload_q if up_down=0) on that edge. The first step occurs on the following enabled edge.
- stop_i: state<=IDLE, count holds. Ignored in IDLE.
- Priority, highest first: reset > load_i > stop_i > start_i > counting.
  - load_i sets count=load_val_i and suppresses counting/terminal for that cycle; the state is unchanged except as below.
  - With load_i and stop_i together, both apply: count is loaded and state goes to IDLE.
  - With load_i and start_i together, the loaded value wins over the start value, but the state/mode/wrap_cnt effects of start still apply.
  - reload_wr_i is independent and may coincide with any of these.
- tc_o: high for exactly the one cycle in which count first shows the post-terminal value (reload value in auto mode, held terminal value in one-shot). Otherwise 0. In one-shot, done_o rises in the same cycle as tc_o.
- wrap_cnt_o: +1 per terminal event, saturates at 2^CNT_W-1, cleared by start_i and reset.
- busy_o = (state==RUN); done_o = (state==DONE).

Test Plan:
1. WIDTH=4. Assert reset for 3 cycles -> count=0, tc_o=0, busy_o=0, done_o=0, wrap_cnt_o=0. Confirm reload_q=15 by running up: 0..15, tc pulses when 0 reappears.
2. Auto up: reload_wr 5, then start_i with up_down=1, en_i=1 -> count 0,1,2,3,4,5,0,1…. tc_o is high on each cycle count returns to 0. wrap_cnt_o=1 after the first wrap, 2 after the second.
3. Auto down with load: in RUN, load_i=1, load_val_i=3, up_down=0 -> 3,2,1,0,5,4…. tc_o is high with the first 5. Drop en_i for 2 cycles -> count holds, no tc.
4. One-shot up, reload=5: start with mode_i=1 -> 0..5, then DONE. done_o=1, busy_o=0, tc_o for one cycle, count stays 5 with en_i=1. start_i restarts at 0 and clears wrap_cnt_o.
5. Out-of-range load, up mode, reload=5: load 12 -> 13,14,15,0 with no tc, then 1..5 -> tc on the next 0. Also apply load_i+stop_i together -> count=load value, state IDLE.
6. Reset mid-run at count=3 with reload_wr_i asserted in the same cycle -> next cycle count=0, IDLE, reload_q=RESET_RELOAD (reset wins). Also apply reload_wr 2 while count=4 in up mode -> terminal uses the new value, so count wraps 4..15,0 and then 0..2.
